rw_burst_fsm: RTL and testbench

Parametrised successor to the single-word read/write transaction FSM that sits between the OS-side memory request interface and the USB protocol/transaction layer. One request addresses a memory page with an OUT transaction, then moves a burst of 1..BURST_MAX data words. Reads use IN transactions and writes use OUT transactions. Each failed transaction is retried up to MAX_RETRY times before the request aborts.

---
 rtl/rw_pkg.sv | 24 ++
 rtl/rw_retry_ctr.sv | 34 +++
 rtl/rw_burst_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_rw_burst_fsm.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rw_pkg.sv
// Shared types for the burst read/write transaction FSM.
package rw_pkg;

   // Controller states: page addressing, write data hand-off, write OUT, read IN
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WDATA = 3'd2,
      WOUT  = 3'd3,
      RIN   = 3'd4
   } rw_state_e;

   // Direction of the request latched in IDLE
   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } rw_op_e;

   // Width of a counter that must hold 0..max_val; never narrower than one bit
   function automatic int cnt_width(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/rw_retry_ctr.sv
// Per-transaction retry counter: counts failed attempts and saturates at MAX_RETRY.
module rw_retry_ctr
   import rw_pkg::*;
#(
   parameter  int MAX_RETRY = 3,
   localparam int CNT_W     = cnt_width(MAX_RETRY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             fail,
   output logic [CNT_W-1:0] count,
   output logic             exhausted
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RETRY);

   logic [CNT_W-1:0] count_reg;

   // Clear wins over a failure in the same cycle; never count past the limit
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (fail && (count_reg != MAX_C)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count     = count_reg;
   assign exhausted = (count_reg == MAX_C);

endmodule

// File: rtl/rw_burst_fsm.sv
// Burst read/write request controller: addresses a memory page with an OUT
// transaction, then moves 1..BURST_MAX words using IN (read) or OUT (write)
// transactions, retrying each failed transaction up to MAX_RETRY times.
module rw_burst_fsm
   import rw_pkg::*;
#(
   parameter  int DATA_W    = 64,
   parameter  int PAGE_W    = 16,
   parameter  int BURST_MAX = 4,
   parameter  int MAX_RETRY = 3,
   localparam int LEN_W     = $clog2(BURST_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read,
   input  logic              write,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic [PAGE_W-1:0] mempage,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] data_from_device,
   input  logic              success,
   input  logic              failure,
   output logic [DATA_W-1:0] data_to_device,
   output logic              in_trans,
   output logic              out_trans,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done,
   output logic              ok
);

   localparam int               CNT_W       = cnt_width(MAX_RETRY);
   localparam logic [CNT_W-1:0] MAX_C       = CNT_W'(MAX_RETRY);
   localparam logic [LEN_W-1:0] BURST_MAX_L = LEN_W'(BURST_MAX);

   rw_state_e         state_reg,     state_next;
   rw_op_e            op_reg,        op_next;
   logic [LEN_W-1:0]  len_reg,       len_next;
   logic [LEN_W-1:0]  beat_reg,      beat_next;
   logic [DATA_W-1:0] dtd_reg,       dtd_next;
   logic [DATA_W-1:0] rd_data_reg,   rd_data_next;
   logic              ok_reg,        ok_next;
   logic              out_trans_reg, out_trans_next;
   logic              in_trans_reg,  in_trans_next;
   logic              rd_valid_reg,  rd_valid_next;
   logic              done_reg,      done_next;

   logic              retry_clr;
   logic              retry_fail;
   logic [CNT_W-1:0]  retry_cnt;
   logic              retry_exhausted;
   logic [LEN_W-1:0]  beat_inc;
   logic              last_beat;

   assign beat_inc  = beat_reg + 1'b1;
   assign last_beat = (beat_inc == len_reg);

   rw_retry_ctr #(
      .MAX_RETRY (MAX_RETRY)
   ) u_retry_ctr (
      .clk       (clk),
      .rst       (rst),
      .clr       (retry_clr),
      .fail      (retry_fail && (retry_cnt != MAX_C)),
      .count     (retry_cnt),
      .exhausted (retry_exhausted)
   );

   // State and all registered outputs; reset drops everything without a done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         op_reg        <= OP_READ;
         len_reg       <= '0;
         beat_reg      <= '0;
         dtd_reg       <= '0;
         rd_data_reg   <= '0;
         ok_reg        <= 1'b0;
         out_trans_reg <= 1'b0;
         in_trans_reg  <= 1'b0;
         rd_valid_reg  <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         op_reg        <= op_next;
         len_reg       <= len_next;
         beat_reg      <= beat_next;
         dtd_reg       <= dtd_next;
         rd_data_reg   <= rd_data_next;
         ok_reg        <= ok_next;
         out_trans_reg <= out_trans_next;
         in_trans_reg  <= in_trans_next;
         rd_valid_reg  <= rd_valid_next;
         done_reg      <= done_next;
      end
   end

   // Next-state and next-output decode; pulses default low, data holds
   always_comb begin
      state_next     = state_reg;
      op_next        = op_reg;
      len_next       = len_reg;
      beat_next      = beat_reg;
      dtd_next       = dtd_reg;
      rd_data_next   = rd_data_reg;
      ok_next        = ok_reg;
      out_trans_next = 1'b0;
      in_trans_next  = 1'b0;
      rd_valid_next  = 1'b0;
      done_next      = 1'b0;
      retry_clr      = 1'b0;
      retry_fail     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (read || write) begin
               op_next   = read ? OP_READ : OP_WRITE;
               len_next  = burst_len;
               beat_next = '0;
               retry_clr = 1'b1;
               ok_next   = 1'b0;
               if ((burst_len == '0) || (burst_len > BURST_MAX_L)) begin
                  // Out-of-range length: answer immediately, no bus activity
                  done_next = 1'b1;
               end else begin
                  state_next     = ADDR;
                  out_trans_next = 1'b1;
                  dtd_next       = DATA_W'(mempage);
               end
            end
         end

         WDATA: begin
            if (wr_valid) begin
               dtd_next       = wr_data;
               out_trans_next = 1'b1;
               state_next     = WOUT;
            end
         end

         ADDR, WOUT, RIN: begin
            // failure dominates success when both arrive together
            if (failure) begin
               if (retry_exhausted) begin
                  done_next  = 1'b1;
                  ok_next    = 1'b0;
                  state_next = IDLE;
               end else begin
                  // Relaunch the same transaction; payload register is untouched
                  retry_fail = 1'b1;
                  if (state_reg == RIN) begin
                     in_trans_next = 1'b1;
                  end else begin
                     out_trans_next = 1'b1;
                  end
               end
            end else if (success) begin
               retry_clr = 1'b1;
               case (state_reg)
                  ADDR: begin
                     if (op_reg == OP_READ) begin
                        state_next    = RIN;
                        in_trans_next = 1'b1;
                     end else begin
                        state_next = WDATA;
                     end
                  end
                  WOUT: begin
                     beat_next = beat_inc;
                     if (last_beat) begin
                        done_next  = 1'b1;
                        ok_next    = 1'b1;
                        state_next = IDLE;
                     end else begin
                        state_next = WDATA;
                     end
                  end
                  RIN: begin
                     rd_data_next  = data_from_device;
                     rd_valid_next = 1'b1;
                     beat_next     = beat_inc;
                     if (last_beat) begin
                        done_next  = 1'b1;
                        ok_next    = 1'b1;
                        state_next = IDLE;
                     end else begin
                        in_trans_next = 1'b1;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign wr_ready       = (state_reg == WDATA);
   assign busy           = (state_reg != IDLE);
   assign data_to_device = dtd_reg;
   assign rd_data        = rd_data_reg;
   assign out_trans      = out_trans_reg;
   assign in_trans       = in_trans_reg;
   assign rd_valid       = rd_valid_reg;
   assign done           = done_reg;
   assign ok             = ok_reg;

endmodule

// File: tb/tb_rw_burst_fsm.sv
// Scoreboard bench for rw_burst_fsm: a zero-latency device model answers every
// launch pulse in the same cycle, expected payloads and read words are queued
// when stimulus is driven and popped when the DUT produces them.
module tb_rw_burst_fsm;

   localparam int DATA_W    = 64;
   localparam int PAGE_W    = 16;
   localparam int BURST_MAX = 4;
   localparam int MAX_RETRY = 3;
   localparam int LEN_W     = $clog2(BURST_MAX + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              read = 1'b0;
   logic              write = 1'b0;
   logic [LEN_W-1:0]  burst_len = '0;
   logic [PAGE_W-1:0] mempage = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [DATA_W-1:0] data_from_device = '0;
   logic              success = 1'b0;
   logic              failure = 1'b0;
   logic [DATA_W-1:0] data_to_device;
   logic              in_trans;
   logic              out_trans;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              busy;
   logic              done;
   logic              ok;

   rw_burst_fsm #(
      .DATA_W    (DATA_W),
      .PAGE_W    (PAGE_W),
      .BURST_MAX (BURST_MAX),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .read             (read),
      .write            (write),
      .burst_len        (burst_len),
      .mempage          (mempage),
      .wr_data          (wr_data),
      .wr_valid         (wr_valid),
      .wr_ready         (wr_ready),
      .data_from_device (data_from_device),
      .success          (success),
      .failure          (failure),
      .data_to_device   (data_to_device),
      .in_trans         (in_trans),
      .out_trans        (out_trans),
      .rd_data          (rd_data),
      .rd_valid         (rd_valid),
      .busy             (busy),
      .done             (done),
      .ok               (ok)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int t0    = 0;

   logic [DATA_W-1:0] exp_out[$];
   logic [DATA_W-1:0] exp_rd[$];
   logic [DATA_W-1:0] dev_words[$];
   logic [DATA_W-1:0] wr_words[$];
   bit                resp_plan[$];
   int                wr_delay = 0;

   int r_out, r_in, r_rdv, r_done_cyc, r_first_out, r_first_rdv, r_last_rdv;
   int r_ready, r_busy, r_wr_acc, r_wr_follow;
   bit r_ok, r_done_rdv, r_timeout;

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic clear_sb();
      exp_out.delete();
      exp_rd.delete();
      dev_words.delete();
      wr_words.delete();
      resp_plan.delete();
   endtask

   // Drive one request strobe; an in-range request is expected to send the page first
   task automatic issue(input bit rd, input bit wr, input int len, input logic [PAGE_W-1:0] page);
      read      = rd;
      write     = wr;
      burst_len = LEN_W'(len);
      mempage   = page;
      t0        = cyc;
      if ((rd || wr) && len >= 1 && len <= BURST_MAX) exp_out.push_back(DATA_W'(page));
      tick();
      read  = 1'b0;
      write = 1'b0;
   endtask

   // Device + OS model: answers pulses per resp_plan, feeds write words after
   // wr_delay ready cycles, pops the scoreboard on every produced payload/word
   task automatic run_req(input int budget, input int stop_at_out);
      logic [DATA_W-1:0] e;
      bit f;
      int wait_n;
      int acc_cyc;
      wait_n = 0; acc_cyc = -10;
      r_out = 0; r_in = 0; r_rdv = 0; r_done_cyc = -1; r_first_out = -1;
      r_first_rdv = -1; r_last_rdv = -1; r_ready = 0; r_busy = 0;
      r_wr_acc = 0; r_wr_follow = 0; r_ok = 1'b0; r_done_rdv = 1'b0; r_timeout = 1'b0;
      for (int i = 0; i < budget; i++) begin
         success = 1'b0; failure = 1'b0; wr_valid = 1'b0;
         if (busy) r_busy++;
         if (wr_ready) r_ready++;
         if (rd_valid) begin
            r_rdv++;
            if (r_first_rdv < 0) r_first_rdv = cyc;
            r_last_rdv = cyc;
            n_cmp++;
            if (exp_rd.size() == 0) begin
               n_bad++;
               $display("FAIL rd_word: got %h at cycle %0d, no word expected", rd_data, cyc);
            end else begin
               e = exp_rd.pop_front();
               if (rd_data !== e) begin
                  n_bad++;
                  $display("FAIL rd_word: got %h expected %h", rd_data, e);
               end
            end
         end
         if (out_trans) begin
            r_out++;
            if (r_first_out < 0) r_first_out = cyc;
            if (acc_cyc == cyc - 1) r_wr_follow++;
            n_cmp++;
            e = '0;
            if (exp_out.size() == 0) begin
               n_bad++;
               $display("FAIL out_payload: got %h at cycle %0d, no OUT expected", data_to_device, cyc);
            end else begin
               e = exp_out.pop_front();
               if (data_to_device !== e) begin
                  n_bad++;
                  $display("FAIL out_payload: got %h expected %h", data_to_device, e);
               end
            end
            if (r_out == stop_at_out) return;
            f = (resp_plan.size() != 0) ? resp_plan.pop_front() : 1'b0;
            if (f) begin
               failure = 1'b1;
               exp_out.push_front(e);
            end else begin
               success = 1'b1;
            end
         end
         if (in_trans) begin
            r_in++;
            f = (resp_plan.size() != 0) ? resp_plan.pop_front() : 1'b0;
            if (f) begin
               failure = 1'b1;
            end else begin
               success = 1'b1;
               data_from_device = (dev_words.size() != 0) ? dev_words.pop_front() : '0;
            end
         end
         if (wr_ready) begin
            if (wait_n == wr_delay) begin
               wr_valid = 1'b1;
               wr_data  = (wr_words.size() != 0) ? wr_words.pop_front() : '0;
               exp_out.push_back(wr_data);
               acc_cyc  = cyc;
               r_wr_acc++;
               wait_n   = 0;
            end else begin
               wait_n++;
            end
         end
         if (done) begin
            r_done_cyc = cyc;
            r_ok       = ok;
            r_done_rdv = rd_valid;
            return;
         end
         tick();
      end
      r_timeout = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({out_trans, in_trans, rd_valid, done, ok, busy, wr_ready} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b expected 0000000", {out_trans, in_trans, rd_valid, done, ok, busy, wr_ready});
      end
      n_cmp++;
      if (data_to_device !== '0 || rd_data !== '0) begin
         n_bad++;
         $display("FAIL reset_data: dtd=%h rd_data=%h expected 0", data_to_device, rd_data);
      end
      rst = 1'b0;
      tick();
      $display("txn reset: done");
   endtask

   task automatic test_read_burst();
      clear_sb();
      dev_words = '{64'hA, 64'hB, 64'hC};
      exp_rd    = '{64'hA, 64'hB, 64'hC};
      issue(1'b1, 1'b0, 3, 16'h1234);
      run_req(50, 0);
      n_cmp++; if (r_timeout) begin n_bad++; $display("FAIL read_timeout: no done within budget"); end
      n_cmp++; if (r_first_out != t0 + 1) begin n_bad++; $display("FAIL read_addr_cycle: got %0d expected %0d", r_first_out, t0 + 1); end
      n_cmp++; if (r_in != 3) begin n_bad++; $display("FAIL read_in_count: got %0d expected 3", r_in); end
      n_cmp++; if (r_first_rdv != t0 + 3) begin n_bad++; $display("FAIL read_first_rdv: got %0d expected %0d", r_first_rdv, t0 + 3); end
      n_cmp++; if (!r_done_rdv || r_done_cyc != r_last_rdv) begin n_bad++; $display("FAIL read_done_align: done %0d last rd_valid %0d", r_done_cyc, r_last_rdv); end
      n_cmp++; if (r_ok !== 1'b1 || r_rdv != 3 || exp_rd.size() != 0) begin n_bad++; $display("FAIL read_result: ok=%b rdv=%0d left=%0d expected ok=1 rdv=3 left=0", r_ok, r_rdv, exp_rd.size()); end
      $display("txn read len=3: in=%0d rdv=%0d done@%0d ok=%b", r_in, r_rdv, r_done_cyc - t0, r_ok);
      tick();
   endtask

   task automatic test_write_burst();
      clear_sb();
      wr_words = '{64'hDEAD, 64'hBEEF};
      wr_delay = 3;
      issue(1'b0, 1'b1, 2, 16'h1234);
      run_req(60, 0);
      wr_delay = 0;
      n_cmp++; if (r_timeout) begin n_bad++; $display("FAIL write_timeout: no done within budget"); end
      n_cmp++; if (r_out != 3 || exp_out.size() != 0) begin n_bad++; $display("FAIL write_out_count: got %0d left %0d expected 3 left 0", r_out, exp_out.size()); end
      n_cmp++; if (r_ready != 8) begin n_bad++; $display("FAIL write_ready_cycles: got %0d expected 8", r_ready); end
      n_cmp++; if (r_wr_follow != 2) begin n_bad++; $display("FAIL write_beat_latency: got %0d prompt OUTs expected 2", r_wr_follow); end
      n_cmp++; if (r_done_cyc != t0 + 12 || r_ok !== 1'b1 || r_in != 0) begin n_bad++; $display("FAIL write_done: done@%0d ok=%b in=%0d expected done@%0d ok=1 in=0", r_done_cyc, r_ok, r_in, t0 + 12); end
      $display("txn write len=2: out=%0d ready=%0d done@%0d ok=%b", r_out, r_ready, r_done_cyc - t0, r_ok);
      tick();
   endtask

   task automatic test_addr_retry();
      clear_sb();
      resp_plan = '{1'b1, 1'b1};
      dev_words = '{64'h5A};
      exp_rd    = '{64'h5A};
      issue(1'b1, 1'b0, 1, 16'h00C3);
      run_req(40, 0);
      n_cmp++; if (r_timeout) begin n_bad++; $display("FAIL retry_timeout: no done within budget"); end
      n_cmp++; if (r_out != 3) begin n_bad++; $display("FAIL retry_out_count: got %0d expected 3", r_out); end
      n_cmp++; if (r_done_cyc != t0 + 5 || r_ok !== 1'b1 || r_in != 1 || r_rdv != 1) begin n_bad++; $display("FAIL retry_result: done@%0d ok=%b in=%0d rdv=%0d expected done@%0d ok=1 in=1 rdv=1", r_done_cyc, r_ok, r_in, r_rdv, t0 + 5); end
      $display("txn addr retry: out=%0d done@%0d ok=%b", r_out, r_done_cyc - t0, r_ok);
      tick();
   endtask

   task automatic test_rin_abort();
      clear_sb();
      resp_plan = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      dev_words = '{64'hA1, 64'hB2};
      exp_rd    = '{64'hA1};
      issue(1'b1, 1'b0, 3, 16'h0042);
      run_req(40, 0);
      n_cmp++; if (r_timeout) begin n_bad++; $display("FAIL abort_timeout: no done within budget"); end
      n_cmp++; if (r_out != 2 || r_in != 5) begin n_bad++; $display("FAIL abort_pulses: out=%0d in=%0d expected out=2 in=5", r_out, r_in); end
      n_cmp++; if (r_rdv != 1 || exp_rd.size() != 0) begin n_bad++; $display("FAIL abort_rdv: got %0d expected 1", r_rdv); end
      n_cmp++; if (r_ok !== 1'b0 || r_done_cyc != t0 + 8) begin n_bad++; $display("FAIL abort_done: done@%0d ok=%b expected done@%0d ok=0", r_done_cyc, r_ok, t0 + 8); end
      $display("txn rin abort: in=%0d rdv=%0d done@%0d ok=%b", r_in, r_rdv, r_done_cyc - t0, r_ok);
      tick();
   endtask

   task automatic test_reject();
      int lens[2];
      lens[0] = 0;
      lens[1] = 5;
      for (int k = 0; k < 2; k++) begin
         clear_sb();
         issue(k == 1, k == 0, lens[k], 16'h7777);
         run_req(10, 0);
         n_cmp++; if (r_done_cyc != t0 + 1 || r_ok !== 1'b0) begin n_bad++; $display("FAIL reject_done len=%0d: done@%0d ok=%b expected done@%0d ok=0", lens[k], r_done_cyc, r_ok, t0 + 1); end
         n_cmp++; if (r_out != 0 || r_in != 0 || r_busy != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL reject_quiet len=%0d: out=%0d in=%0d busy=%0d expected 0", lens[k], r_out, r_in, r_busy); end
         tick();
         n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || out_trans !== 1'b0) begin n_bad++; $display("FAIL reject_after len=%0d: done=%b busy=%b out=%b expected 0", lens[k], done, busy, out_trans); end
         $display("txn reject len=%0d: done@%0d ok=%b", lens[k], r_done_cyc - t0, r_ok);
      end
   endtask

   task automatic test_both_strobes();
      clear_sb();
      dev_words = '{64'h77};
      exp_rd    = '{64'h77};
      issue(1'b1, 1'b1, 1, 16'h00FF);
      run_req(30, 0);
      n_cmp++; if (r_timeout || r_in != 1 || r_rdv != 1 || r_ready != 0 || r_ok !== 1'b1) begin n_bad++; $display("FAIL both_strobes: in=%0d rdv=%0d ready=%0d ok=%b expected read path in=1 rdv=1 ready=0 ok=1", r_in, r_rdv, r_ready, r_ok); end
      $display("txn read+write strobe: in=%0d rdv=%0d ok=%b", r_in, r_rdv, r_ok);
      tick();
   endtask

   task automatic test_reset_mid_wout();
      clear_sb();
      wr_words = '{64'hDEAD, 64'hBEEF};
      issue(1'b0, 1'b1, 2, 16'h1234);
      run_req(30, 2);
      n_cmp++; if (r_out != 2 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_setup: out=%0d busy=%b expected 2 1", r_out, busy); end
      rst = 1'b1;
      tick();
      n_cmp++; if ({out_trans, in_trans, rd_valid, done, ok, busy, wr_ready} !== 7'b0) begin n_bad++; $display("FAIL rst_ctrl: got %b expected 0000000", {out_trans, in_trans, rd_valid, done, ok, busy, wr_ready}); end
      n_cmp++; if (data_to_device !== '0 || rd_data !== '0) begin n_bad++; $display("FAIL rst_data: dtd=%h rd_data=%h expected 0", data_to_device, rd_data); end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_silent: done=%b busy=%b expected 0 0", done, busy); end
      end
      clear_sb();
      dev_words = '{64'h11, 64'h22};
      exp_rd    = '{64'h11, 64'h22};
      issue(1'b1, 1'b0, 2, 16'h0100);
      run_req(30, 0);
      n_cmp++; if (r_timeout || r_ok !== 1'b1 || r_rdv != 2 || exp_rd.size() != 0) begin n_bad++; $display("FAIL rst_recover: ok=%b rdv=%0d expected ok=1 rdv=2", r_ok, r_rdv); end
      $display("txn reset mid-WOUT then read len=2: rdv=%0d ok=%b", r_rdv, r_ok);
      tick();
   endtask

   initial begin
      test_reset();
      test_read_burst();
      test_write_burst();
      test_addr_retry();
      test_rin_abort();
      test_reject();
      test_both_strobes();
      test_reset_mid_wout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
